mvm_array_con: RTL and testbench
================================

Name: mvm_array_con

Overview:
- Parametrised matrix-vector controller. Computes NUM_PE dot products in parallel (y = M·x) over a shared input vector.
- Loads vector x from the external BRAM into a global buffer, and each matrix row into a per-lane local buffer.
- Streams one element per cycle to NUM_PE MAC lanes, then writes the NUM_PE results back to the same BRAM.
- Successor of the single-PE controller: multi-lane, runtime vector length, BRAM write-back, busy/done handshake.

Parameters:
- VECTOR_SIZE, 16, maximum vector length and buffer depth per lane.
- NUM_PE, 4, number of MAC lanes / matrix rows.
- ADDR_W, 10, BRAM word-address width.
- RES_BASE, (NUM_PE+1)*VECTOR_SIZE, BRAM word address of result y[0].

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- start  in  1  start request, sampled only in IDLE
- vlen  in  $clog2(VECTOR_SIZE)+1  vector length, latched on start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- rdaddr  out  ADDR_W  BRAM read address
- rddata  in  32  BRAM read data, 1-cycle latency
- wren  out  1  BRAM write enable
- wraddr  out  ADDR_W  BRAM write address
- wrdata  out  32  BRAM write data

Behaviour:
- Reset: all outputs 0, state IDLE, accumulators and buffers-valid cleared. Reset mid-operation aborts immediately: no further wren, no done.
- BRAM layout: x[i] at word i. Row p element i at word (p+1)*VECTOR_SIZE+i. y[p] written to RES_BASE+p.
- vlen latched on start. vlen==0 or vlen>VECTOR_SIZE is treated as VECTOR_SIZE (L = effective length).
- States: IDLE -> LOAD_X -> LOAD_M -> CALC -> WRITE -> DONE -> IDLE. No other transitions except reset.
- IDLE:
  - start=1 -> LOAD_X on the next edge; busy rises with the state change.
  - start is ignored in all other states.
- LOAD_X:
  - Issues rdaddr 0..L-1 on consecutive cycles.
  - Captures rddata one cycle later into global[i].
  - Takes L+1 cycles. All NUM_PE accumulators are cleared on entry.
- LOAD_M:
  - For p=0..NUM_PE-1 in sequence, issues rdaddr (p+1)*VECTOR_SIZE+i for i=0..L-1 and captures into local_p[i].
  - Each row takes L+1 cycles; total NUM_PE*(L+1).
  - rdaddr is 0 whenever no read is issued.
- CALC:
  - Index k=0..L-1 read from all buffers in parallel.
  - Registered one cycle later, then acc_p <= acc_p + local_p[k]*global[k].
  - Arithmetic: signed 32x32 product, low 32 bits kept, 32-bit wrap-around accumulation, no saturation.
  - Takes L+1 cycles.
- WRITE:
  - For p=0..NUM_PE-1, one per cycle: wren=1, wraddr=RES_BASE+p, wrdata=acc_p.
  - Takes NUM_PE cycles. wren, wraddr and wrdata are 0 outside WRITE.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE with busy=0.
- Latency: done goes high (NUM_PE+2)*(L+1)+NUM_PE+1 cycles after the edge that samples start.
- A start pulse held high through DONE does not relaunch until IDLE samples it again, i.e. at least 1 idle cycle between runs.
- Buffer entries beyond L keep stale values and are never read.

Test Plan:
- Reset/idle: aresetn=0 for 3 cycles -> busy, done, wren, rdaddr, wraddr, wrdata all 0; start while aresetn=0 ignored.
- Basic run, NUM_PE=4, vlen=16: x[i]=1, row p elements = p+1 -> wren pulses write 16, 32, 48, 64 to RES_BASE..RES_BASE+3; done exactly 107 cycles after the start edge.
- Short/clamp: vlen=3, x={2,3,4}, row0={1,1,1}, row1={-1,0,2}, rows 2 and 3 zero -> y={9,6,0,0}; done after 6*4+5=29 cycles. Then vlen=0 -> behaves as vlen=16.
- Wrap-around: x[0]=row0[0]=32'h0001_0000, vlen=1 -> y[0]=0 (low 32 bits); x[0]=-2, row0[0]=3 -> y[0]=32'hFFFF_FFFA.
- Back-to-back and ignored start: pulse start during CALC -> no effect. Second start in IDLE after done -> accumulators cleared, identical results to the first run.
- Reset mid-operation: aresetn=0 during LOAD_M -> next cycle IDLE, no wren, no done. A subsequent full run gives correct results.

Source files
------------

// File: rtl/mvm_array_con.sv
// Matrix-vector controller: loads x and NUM_PE matrix rows from a shared BRAM,
// runs NUM_PE parallel MAC lanes over the runtime vector length, writes y back.
module mvm_array_con #(
  parameter int VECTOR_SIZE = 16,
  parameter int NUM_PE      = 4,
  parameter int ADDR_W      = 10,
  parameter int RES_BASE    = (NUM_PE + 1) * VECTOR_SIZE
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           start,
  input  logic [$clog2(VECTOR_SIZE):0]   vlen,
  output logic                           busy,
  output logic                           done,
  output logic [ADDR_W-1:0]              rdaddr,
  input  logic [31:0]                    rddata,
  output logic                           wren,
  output logic [ADDR_W-1:0]              wraddr,
  output logic [31:0]                    wrdata
);

  localparam int DATA_W = 32;
  localparam int LEN_W  = $clog2(VECTOR_SIZE) + 1;
  localparam int IDX_W  = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
  localparam int PE_W   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_X, S_LOAD_M, S_CALC, S_WRITE, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] cnt;
  logic [PE_W-1:0]  row;
  logic             cnt_last;
  logic             row_last;

  logic signed [DATA_W-1:0] gbuf [VECTOR_SIZE];
  logic signed [DATA_W-1:0] lbuf [NUM_PE][VECTOR_SIZE];
  logic signed [DATA_W-1:0] acc  [NUM_PE];

  logic signed [DATA_W-1:0] gx_p0;
  logic signed [DATA_W-1:0] lm_p0 [NUM_PE];
  logic                     vld_p0;

  // Out-of-range lengths (0 or above the buffer depth) fall back to full depth.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] v);
    if (v == '0 || int'(v) > VECTOR_SIZE) return LEN_W'(VECTOR_SIZE);
    return v;
  endfunction

  // Keep only the low word of the full product and let the sum wrap.
  function automatic logic signed [DATA_W-1:0] mac_wrap(
    input logic signed [DATA_W-1:0] a_acc,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [2*DATA_W-1:0] prod;
    prod = a * b;
    return a_acc + $signed(prod[DATA_W-1:0]);
  endfunction

  assign cnt_last = (cnt == len);
  assign row_last = (row == PE_W'(NUM_PE - 1));

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    rdaddr    = '0;
    wren      = 1'b0;
    wraddr    = '0;
    wrdata    = '0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD_X;
      end
      S_LOAD_X: begin
        if (!cnt_last) rdaddr = ADDR_W'(cnt);
        else           state_nxt = S_LOAD_M;
      end
      S_LOAD_M: begin
        if (!cnt_last) rdaddr = ADDR_W'((int'(row) + 1) * VECTOR_SIZE + int'(cnt));
        else if (row_last) state_nxt = S_CALC;
      end
      S_CALC: begin
        if (cnt_last) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        wren   = 1'b1;
        wraddr = ADDR_W'(RES_BASE + int'(row));
        wrdata = acc[row];
        if (row_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sequencing counters and lane accumulators; accumulators clear on reset and on launch.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      len    <= '0;
      cnt    <= '0;
      row    <= '0;
      vld_p0 <= 1'b0;
      for (int p = 0; p < NUM_PE; p++) acc[p] <= '0;
    end else begin
      vld_p0 <= (state == S_CALC) && !cnt_last;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          row <= '0;
          if (start) begin
            len <= eff_len(vlen);
            for (int p = 0; p < NUM_PE; p++) acc[p] <= '0;
          end
        end
        S_LOAD_X, S_CALC: begin
          cnt <= cnt_last ? '0 : cnt + 1'b1;
        end
        S_LOAD_M: begin
          if (cnt_last) begin
            cnt <= '0;
            row <= row_last ? '0 : row + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WRITE: begin
          row <= row_last ? '0 : row + 1'b1;
        end
        default: ;
      endcase
      // Stage p1: accumulate the operand pair registered in stage p0.
      if (vld_p0) begin
        for (int p = 0; p < NUM_PE; p++) acc[p] <= mac_wrap(acc[p], lm_p0[p], gx_p0);
      end
    end
  end

  // BRAM data lands one cycle after its address, hence the cnt-1 write index.
  always_ff @(posedge aclk) begin
    if (state == S_LOAD_X && cnt != '0) gbuf[IDX_W'(cnt - 1'b1)] <= rddata;
    if (state == S_LOAD_M && cnt != '0) lbuf[row][IDX_W'(cnt - 1'b1)] <= rddata;
    // Stage p0: fetch element cnt from every buffer in parallel.
    if (state == S_CALC && !cnt_last) begin
      gx_p0 <= gbuf[IDX_W'(cnt)];
      for (int p = 0; p < NUM_PE; p++) lm_p0[p] <= lbuf[p][IDX_W'(cnt)];
    end
  end

endmodule

// File: tb/tb_mvm_array_con.sv
// Self-checking bench for mvm_array_con: BRAM model, dot-product reference,
// table-driven random runs and hand-written corner sequences.
module tb_mvm_array_con;

  localparam int VS = 16;
  localparam int NP = 4;
  localparam int AW = 10;
  localparam int RB = (NP + 1) * VS;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic [4:0]    vlen = '0;
  logic          busy, done, wren;
  logic [AW-1:0] rdaddr, wraddr;
  logic [31:0]   rddata, wrdata;

  logic [31:0] mem [1 << AW];
  logic [31:0] exp_y [NP];
  logic [AW-1:0] wq_a [$];
  logic [31:0]   wq_d [$];
  int done_cnt = 0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] vl;
    int         lat;
  } vec_t;
  vec_t vecs [8];

  mvm_array_con #(.VECTOR_SIZE(VS), .NUM_PE(NP), .ADDR_W(AW), .RES_BASE(RB)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .vlen(vlen),
    .busy(busy), .done(done), .rdaddr(rdaddr), .rddata(rddata),
    .wren(wren), .wraddr(wraddr), .wrdata(wrdata)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) rddata <= mem[rdaddr];

  always @(negedge aclk) begin
    if (wren) begin
      wq_a.push_back(wraddr);
      wq_d.push_back(wrdata);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic model(input int L);
    for (int p = 0; p < NP; p++) begin
      int s;
      s = 0;
      for (int i = 0; i < L; i++) s += int'(mem[(p + 1) * VS + i]) * int'(mem[i]);
      exp_y[p] = s;
    end
  endtask

  task automatic fill_random();
    for (int a = 0; a < RB; a++) mem[a] = $urandom;
  endtask

  task automatic clear_inputs();
    for (int a = 0; a < RB; a++) mem[a] = '0;
  endtask

  task automatic do_run(input string nm, input logic [4:0] vl, input int exp_lat,
                        input int pulse_at, input bit use_model);
    int cyc, L, w0;
    bit got;
    L = (vl == 0 || int'(vl) > VS) ? VS : int'(vl);
    if (use_model) model(L);
    w0 = wq_a.size();
    @(negedge aclk);
    vlen  = vl;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    cyc = 1;
    chk($sformatf("%s busy_rise", nm), {31'b0, busy}, 32'd1);
    got = 1'b0;
    while (cyc < 2000) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      start = (cyc == pulse_at);
      @(negedge aclk);
      cyc++;
    end
    start = 1'b0;
    chk($sformatf("%s done_seen", nm), {31'b0, got}, 32'd1);
    chk($sformatf("%s latency", nm), cyc, exp_lat);
    chk($sformatf("%s busy_in_done", nm), {31'b0, busy}, 32'd1);
    @(negedge aclk);
    chk($sformatf("%s done_pulse_width", nm), {31'b0, done}, 32'd0);
    chk($sformatf("%s busy_after", nm), {31'b0, busy}, 32'd0);
    chk($sformatf("%s write_count", nm), wq_a.size() - w0, NP);
    for (int p = 0; p < NP; p++) begin
      if (w0 + p < wq_a.size()) begin
        chk($sformatf("%s wraddr[%0d]", nm, p), {22'b0, wq_a[w0 + p]}, RB + p);
        chk($sformatf("%s y[%0d]", nm, p), wq_d[w0 + p], exp_y[p]);
      end
    end
  endtask

  initial begin
    int w0, d0;
    vecs[0] = '{5'd16, 107};
    vecs[1] = '{5'd1,  17};
    vecs[2] = '{5'd8,  59};
    vecs[3] = '{5'd0,  107};
    vecs[4] = '{5'd20, 107};
    vecs[5] = '{5'd5,  41};
    vecs[6] = '{5'd31, 107};
    vecs[7] = '{5'd2,  23};

    for (int a = 0; a < (1 << AW); a++) mem[a] = '0;

    // Reset with start held high: nothing may launch.
    aresetn = 1'b0;
    start   = 1'b1;
    vlen    = 5'd4;
    repeat (3) @(negedge aclk);
    chk("reset busy",   {31'b0, busy},  32'd0);
    chk("reset done",   {31'b0, done},  32'd0);
    chk("reset wren",   {31'b0, wren},  32'd0);
    chk("reset rdaddr", {22'b0, rdaddr}, 32'd0);
    chk("reset wraddr", {22'b0, wraddr}, 32'd0);
    chk("reset wrdata", wrdata, 32'd0);
    aresetn = 1'b1;
    start   = 1'b0;
    repeat (2) @(negedge aclk);
    chk("idle after reset", {31'b0, busy}, 32'd0);

    // Basic: x all ones, row p filled with p+1.
    for (int i = 0; i < VS; i++) begin
      mem[i] = 32'd1;
      for (int p = 0; p < NP; p++) mem[(p + 1) * VS + i] = p + 1;
    end
    exp_y = '{32'd16, 32'd32, 32'd48, 32'd64};
    do_run("basic", 5'd16, 107, -1, 1'b0);

    // Short vector with signed entries.
    clear_inputs();
    mem[0] = 32'd2;  mem[1] = 32'd3;  mem[2] = 32'd4;
    mem[VS] = 32'd1; mem[VS + 1] = 32'd1; mem[VS + 2] = 32'd1;
    mem[2 * VS] = 32'hFFFF_FFFF; mem[2 * VS + 1] = 32'd0; mem[2 * VS + 2] = 32'd2;
    exp_y = '{32'd9, 32'd6, 32'd0, 32'd0};
    do_run("short", 5'd3, 29, -1, 1'b0);
    fill_random();
    do_run("clamp0", 5'd0, 107, -1, 1'b1);

    // Wrap-around of product and sum.
    clear_inputs();
    mem[0] = 32'h0001_0000; mem[VS] = 32'h0001_0000;
    exp_y = '{32'd0, 32'd0, 32'd0, 32'd0};
    do_run("wrap_prod", 5'd1, 17, -1, 1'b0);
    mem[0] = 32'hFFFF_FFFE; mem[VS] = 32'd3;
    exp_y = '{32'hFFFF_FFFA, 32'd0, 32'd0, 32'd0};
    do_run("wrap_neg", 5'd1, 17, -1, 1'b0);

    // Table of lengths with random data.
    for (int t = 0; t < 8; t++) begin
      fill_random();
      do_run($sformatf("vec%0d", t), vecs[t].vl, vecs[t].lat, -1, 1'b1);
    end

    // Start pulsed during CALC is ignored; an immediate rerun repeats results.
    fill_random();
    do_run("calc_start", 5'd16, 107, 90, 1'b1);
    repeat (3) @(negedge aclk);
    chk("no relaunch", {31'b0, busy}, 32'd0);
    do_run("b2b_a", 5'd7, 6 * 8 + 5, -1, 1'b1);
    do_run("b2b_b", 5'd7, 6 * 8 + 5, -1, 1'b1);

    // Reset during LOAD_M aborts without writes or done.
    fill_random();
    @(negedge aclk);
    vlen  = 5'd16;
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    repeat (30) @(negedge aclk);
    chk("midreset busy before", {31'b0, busy}, 32'd1);
    w0 = wq_a.size();
    d0 = done_cnt;
    aresetn = 1'b0;
    @(negedge aclk);
    chk("midreset busy", {31'b0, busy}, 32'd0);
    chk("midreset rdaddr", {22'b0, rdaddr}, 32'd0);
    aresetn = 1'b1;
    repeat (150) @(negedge aclk);
    chk("midreset no wren", wq_a.size() - w0, 32'd0);
    chk("midreset no done", done_cnt - d0, 32'd0);
    chk("midreset idle", {31'b0, busy}, 32'd0);
    do_run("after_reset", 5'd16, 107, -1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
